// File: rtl/core_array_seq.sv
// Staggered reset-release sequencer for an array of cores, plus per-core one-deep result
// slots drained round-robin onto a single valid/ready output with sticky drop flags.
module core_array_seq #(
  parameter int  N_CORES  = 23,
  parameter int  DATA_W   = 28,
  parameter int  EN_W     = 4,
  parameter int  OUT_CODE = 1,
  parameter int  STAGGER  = 20,
  localparam int ID_W     = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rearm,
  output logic [N_CORES-1:0]        core_rst,
  output logic                      all_released,
  input  logic [N_CORES*DATA_W-1:0] core_io_out,
  input  logic [N_CORES*EN_W-1:0]   core_out_en,
  output logic [DATA_W-1:0]         out_data,
  output logic [ID_W-1:0]           out_id,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_CORES-1:0]        overflow
);

  localparam int               CNT_W    = (STAGGER > 1) ? $clog2(STAGGER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGGER - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_CORES - 1);
  localparam logic [EN_W-1:0]  CODE     = EN_W'(OUT_CODE);

  typedef enum logic [1:0] {S_IDLE, S_RELEASE, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [N_CORES-1:0] core_rst_q, core_rst_d;
  logic               all_rel_q, all_rel_d;
  logic [ID_W-1:0]    idx_q, idx_d, idx_inc;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [N_CORES-1:0] full_q, full_d;
  logic [N_CORES-1:0] ovf_q, ovf_d;
  logic [DATA_W-1:0]  slot_q [N_CORES];
  logic [N_CORES-1:0] cap, load, drain;

  logic               out_valid_q;
  logic [DATA_W-1:0]  out_data_q;
  logic [ID_W-1:0]    out_id_q;
  logic [ID_W-1:0]    ptr_q, ptr_d;

  logic               loadable, gnt_found, do_grant;
  logic [ID_W-1:0]    gnt_id, scan_id;
  int                 scan;

  // Release sequencer: one core_rst bit cleared every STAGGER edges.
  always_comb begin
    state_d    = state_q;
    core_rst_d = core_rst_q;
    all_rel_d  = all_rel_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    idx_inc    = idx_q + 1'b1;
    if (rearm) begin
      core_rst_d = '1;
      all_rel_d  = 1'b0;
      idx_d      = '0;
      cnt_d      = '0;
      state_d    = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          core_rst_d[0] = 1'b0;
          idx_d         = '0;
          cnt_d         = '0;
          if (N_CORES == 1) begin
            state_d   = S_DONE;
            all_rel_d = 1'b1;
          end else begin
            state_d = S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d               = '0;
            idx_d               = idx_inc;
            core_rst_d[idx_inc] = 1'b0;
            if (idx_inc == ID_LAST) begin
              state_d   = S_DONE;
              all_rel_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      core_rst_q <= '1;
      all_rel_q  <= 1'b0;
      idx_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      core_rst_q <= core_rst_d;
      all_rel_q  <= all_rel_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
    end
  end

  // Round-robin scan: first full slot at or above the pointer, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    scan      = 0;
    scan_id   = '0;
    for (int k = 0; k < N_CORES; k++) begin
      scan = int'(ptr_q) + k;
      if (scan >= N_CORES) scan = scan - N_CORES;
      scan_id = ID_W'(scan);
      if (!gnt_found && full_q[scan_id]) begin
        gnt_found = 1'b1;
        gnt_id    = scan_id;
      end
    end
  end

  assign loadable = !out_valid_q || out_ready;
  assign do_grant = loadable && gnt_found && !rearm;
  assign ptr_d    = (gnt_id == ID_LAST) ? '0 : gnt_id + 1'b1;

  // A slot drained on this edge may take a new result without counting as a drop.
  generate
    for (genvar gi = 0; gi < N_CORES; gi++) begin : g_slot
      assign cap[gi]    = (core_out_en[gi*EN_W +: EN_W] == CODE) && !core_rst_q[gi];
      assign drain[gi]  = do_grant && (gnt_id == ID_W'(gi));
      assign load[gi]   = !rearm && cap[gi] && (!full_q[gi] || drain[gi]);
      assign full_d[gi] = rearm ? 1'b0 : (cap[gi] ? 1'b1 : (drain[gi] ? 1'b0 : full_q[gi]));
      assign ovf_d[gi]  = ovf_q[gi] | (!rearm && cap[gi] && full_q[gi] && !drain[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= '0;
      ovf_q  <= '0;
      for (int i = 0; i < N_CORES; i++) slot_q[i] <= '0;
    end else begin
      full_q <= full_d;
      ovf_q  <= ovf_d;
      for (int i = 0; i < N_CORES; i++) begin
        if (load[i]) slot_q[i] <= core_io_out[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      ptr_q       <= '0;
    end else if (loadable) begin
      if (do_grant) begin
        out_valid_q <= 1'b1;
        out_data_q  <= slot_q[gnt_id];
        out_id_q    <= gnt_id;
        ptr_q       <= ptr_d;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign core_rst     = core_rst_q;
  assign all_released = all_rel_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_id       = out_id_q;
  assign overflow     = ovf_q;

endmodule
